// File: rtl/fft_ctrl_in_pkg.sv
// Shared definitions for the FFT RAM-to-sink input controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_ctrl_in_pkg;

    // One-hot controller states, common with the FFT output-side controller
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_READ  = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

    // Sample RAM word layout: {re, im}, each a signed 32-bit value
    localparam int RE_MSB = 63;
    localparam int RE_LSB = 32;
    localparam int IM_MSB = 31;
    localparam int IM_LSB = 0;

    // Skid FIFO geometry
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

endpackage

// File: rtl/fft_ctrl_skid_fifo.sv
// Purpose: 4-entry synchronous FIFO holding saturated samples plus sop/eop tags.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: head holds until pop; pushes while full are dropped (upstream credit keeps it from filling).
module fft_ctrl_skid_fifo
    import fft_ctrl_in_pkg::*;
#(
    parameter int WIDTH = 34
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  empty
);

    logic [WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && (count != FIFO_CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];
    assign empty   = (count == '0);

    // Storage, pointers and occupancy; storage is cleared so outputs read 0 out of reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fft_ctrl_in.sv
// Purpose: streams one N_PTS-sample frame from the sample RAM into the FFT core's Avalon-ST sink.
// Latency: START sampled at edge t -> rden after t+1 -> first valid after t+3; then 1 sample/cycle.
// Backpressure: ready low stalls the skid FIFO head; reads are issued only while FIFO + in-flight < 4.
module fft_ctrl_in
    import fft_ctrl_in_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATAIN_WIDTH  = 64,
    parameter int DATAOUT_WIDTH = 16,
    parameter int N_PTS         = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic                     INVERSE,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic                     rden,
    input  logic [DATAIN_WIDTH-1:0]  datain,
    output logic                     valid,
    input  logic                     ready,
    output logic                     sop,
    output logic                     eop,
    output logic [DATAOUT_WIDTH-1:0] dataout_re,
    output logic [DATAOUT_WIDTH-1:0] dataout_im,
    output logic                     inverse,
    output logic [1:0]               error
);

    localparam int DW = DATAOUT_WIDTH;
    localparam int FW = 2 * DW + 2;
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(N_PTS - 1);
    localparam logic signed [31:0]  SAT_MAX  = {{(33 - DW){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [31:0]  SAT_MIN  = ~SAT_MAX;

    // Clamp a signed 32-bit component into the signed DW-bit sink range
    function automatic logic [DW-1:0] sat(input logic signed [31:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end
        return v[DW-1:0];
    endfunction

    state_t                state;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic [ADDR_WIDTH:0]   wr_cnt;
    logic                  q_vld;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [FIFO_CNT_W-1:0] inflight;
    logic                  issue;
    logic                  start_acc;
    logic                  pop;
    logic                  fifo_empty;
    logic [FW-1:0]         push_dat;
    logic [FW-1:0]         head_dat;
    logic                  head_sop;
    logic                  head_eop;

    // Credit: FIFO entries plus reads still travelling through the RAM (rden stage and q stage)
    assign inflight  = fifo_count + FIFO_CNT_W'(rden) + FIFO_CNT_W'(q_vld);
    assign issue     = (state == ST_READ) && (rd_cnt <= LAST_CNT) && (inflight < FIFO_CNT_W'(FIFO_DEPTH));
    assign start_acc = (state == ST_IDLE) && START;
    assign pop       = valid && ready;

    assign push_dat = {sat(datain[RE_MSB:RE_LSB]), sat(datain[IM_MSB:IM_LSB]),
                       (wr_cnt == '0), (wr_cnt == LAST_CNT)};

    assign {dataout_re, dataout_im, head_sop, head_eop} = head_dat;
    assign valid = !fifo_empty;
    assign sop   = valid && head_sop;
    assign eop   = valid && head_eop;
    assign error = 2'b00;

    // Frame sequencing, status flags, latched direction and read-issue count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            inverse <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        state   <= ST_READ;
                        BUSY    <= 1'b1;
                        inverse <= INVERSE;
                        rd_cnt  <= '0;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST_CNT) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_eop) begin
                        state <= ST_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM read port and the one-cycle read-data tracking stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rden  <= 1'b0;
            addr  <= '0;
            q_vld <= 1'b0;
        end else begin
            rden  <= issue;
            q_vld <= rden;
            if (issue) begin
                addr <= rd_cnt[ADDR_WIDTH-1:0];
            end
        end
    end

    // Sample index at the FIFO input, used to tag sop and eop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_cnt <= '0;
        end else if (start_acc) begin
            wr_cnt <= '0;
        end else if (q_vld) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

    fft_ctrl_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (q_vld),
        .pop   (pop),
        .din   (push_dat),
        .dout  (head_dat),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fft_ctrl_in.sv
// Purpose: directed self-checking bench for fft_ctrl_in with N_PTS=8, 16-bit sink samples.
// Latency: checks first valid at START edge + 3 and DONE one cycle after the eop handshake.
// Backpressure: ready driven all-ones, random, or held low on eop.
module tb_fft_ctrl_in;

    localparam int AW = 4;
    localparam int NP = 8;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        INVERSE;
    logic        BUSY;
    logic        DONE;
    logic [AW-1:0] addr;
    logic        rden;
    logic [63:0] datain;
    logic        valid;
    logic        ready;
    logic        sop;
    logic        eop;
    logic [15:0] dataout_re;
    logic [15:0] dataout_im;
    logic        inverse;
    logic [1:0]  error;

    fft_ctrl_in #(
        .ADDR_WIDTH    (AW),
        .DATAIN_WIDTH  (64),
        .DATAOUT_WIDTH (16),
        .N_PTS         (NP)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .INVERSE    (INVERSE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .addr       (addr),
        .rden       (rden),
        .datain     (datain),
        .valid      (valid),
        .ready      (ready),
        .sop        (sop),
        .eop        (eop),
        .dataout_re (dataout_re),
        .dataout_im (dataout_im),
        .inverse    (inverse),
        .error      (error)
    );

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        sop;
        logic        eop;
        logic        inv;
        int          cyc;
    } acc_t;

    logic [63:0] mem [16];
    logic [15:0] exp_re [NP];
    logic [15:0] exp_im [NP];
    acc_t        accq [$];
    acc_t        a;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    int          eop_stall = 0;
    int          stab_bad = 0;
    int          inv_bad = 0;
    int          max_addr = 0;
    int          rmode = 0;
    int          hold_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_out;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Sample RAM with one-cycle read latency
    always @(posedge CLK) begin
        if (rden) datain <= mem[addr];
    end

    // ready driver: 0 = always ready, 1 = random, 2 = hold low for 5 cycles while eop is shown
    always begin
        @(posedge CLK);
        #1;
        if (rmode == 2) begin
            if (valid && eop && hold_cnt < 5) begin
                ready = 1'b0;
                hold_cnt++;
            end else begin
                ready = 1'b1;
            end
        end else begin
            hold_cnt = 0;
            ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: record handshakes, DONE, stall stability and read-credit bounds
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ({valid, sop, eop, dataout_re, dataout_im, 1'b0} != prev_out)) stab_bad++;
            prev_stall = valid && !ready;
            prev_out   = {valid, sop, eop, dataout_re, dataout_im, 1'b0};
            if (valid && ready) begin
                a.re  = dataout_re;
                a.im  = dataout_im;
                a.sop = sop;
                a.eop = eop;
                a.inv = inverse;
                a.cyc = cyc;
                accq.push_back(a);
            end
            if (valid && eop && !ready) eop_stall++;
            if (DONE) begin
                done_n++;
                done_cyc = cyc;
            end
            if (int'(dut.fifo_count) + int'(rden) + int'(dut.q_vld) > 4) inv_bad++;
            if (rden && int'(addr) > max_addr) max_addr = int'(addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic inv, output int sc);
        INVERSE = inv;
        START = 1'b1;
        tick();
        sc = cyc;
        START = 1'b0;
    endtask

    task automatic wait_acc(input string tag, input int n);
        for (int i = 0; i < 200 && accq.size() < n; i++) tick();
        chk({tag, " wait"}, 64'(accq.size() >= n), 1);
    endtask

    task automatic check_frame(input string tag, input int b, input int dn, input int sc,
                               input bit timing, input logic inv);
        for (int i = 0; i < 300 && done_n == dn; i++) tick();
        chk({tag, " done"}, done_n - dn, 1);
        chk({tag, " count"}, accq.size() - b, NP);
        for (int i = 0; i < NP; i++) begin
            if (b + i < accq.size()) begin
                chk({tag, " re"}, accq[b+i].re, exp_re[i]);
                chk({tag, " im"}, accq[b+i].im, exp_im[i]);
                chk({tag, " sop"}, accq[b+i].sop, 64'(i == 0));
                chk({tag, " eop"}, accq[b+i].eop, 64'(i == NP - 1));
                chk({tag, " inv"}, accq[b+i].inv, inv);
            end
        end
        if (accq.size() >= b + NP) begin
            if (timing) begin
                chk({tag, " first"}, accq[b].cyc, sc + 3);
                chk({tag, " span"}, accq[b+NP-1].cyc - accq[b].cyc, NP - 1);
            end
            chk({tag, " done cyc"}, done_cyc, accq[b+NP-1].cyc + 1);
        end
    endtask

    task automatic set_default_exp();
        for (int k = 0; k < NP; k++) begin
            mem[k]    = {32'(k), 32'(-k)};
            exp_re[k] = 16'(k);
            exp_im[k] = 16'(-k);
        end
    endtask

    initial begin
        int b;
        int dn;
        int sc;
        int es0;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        set_default_exp();
        START   = 1'b0;
        INVERSE = 1'b0;
        RST     = 1'b0;
        #1 RST  = 1'b1;
        #2;
        chk("reset outs", {BUSY, DONE, addr, rden, valid, sop, eop, dataout_re, dataout_im, inverse, error}, 0);
        repeat (2) tick();
        RST = 1'b0;
        tick();

        // Basic frame, ready always high
        b = accq.size(); dn = done_n;
        pulse_start(1'b0, sc);
        chk("busy", BUSY, 1);
        check_frame("f1", b, dn, sc, 1, 1'b0);
        chk("idle busy", BUSY, 0);
        repeat (3) tick();

        // Random ready, direction latched then input changed
        rmode = 1;
        b = accq.size(); dn = done_n;
        pulse_start(1'b1, sc);
        INVERSE = 1'b0;
        check_frame("f2", b, dn, sc, 0, 1'b1);
        rmode = 0;
        repeat (3) tick();

        // Saturation corners
        mem[0] = {32'h0001_0000, 32'hFFFE_FFFF}; exp_re[0] = 16'h7FFF; exp_im[0] = 16'h8000;
        mem[1] = {32'hFFFF_FFF0, 32'h0000_7FFF}; exp_re[1] = 16'hFFF0; exp_im[1] = 16'h7FFF;
        mem[2] = {32'h8000_0000, 32'h0000_8000}; exp_re[2] = 16'h8000; exp_im[2] = 16'h7FFF;
        mem[3] = {32'hFFFF_8000, 32'hFFFF_7FFF}; exp_re[3] = 16'h8000; exp_im[3] = 16'h8000;
        b = accq.size(); dn = done_n;
        pulse_start(1'b0, sc);
        check_frame("sat", b, dn, sc, 1, 1'b0);
        set_default_exp();
        repeat (3) tick();

        // START mid-frame ignored; START on DONE ignored, accepted one cycle later
        b = accq.size(); dn = done_n;
        pulse_start(1'b0, sc);
        wait_acc("s2", b + 3);
        START = 1'b1; tick(); START = 1'b0;
        wait_acc("s5", b + 6);
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 100 && !DONE; i++) tick();
        chk("f4 done seen", DONE, 1);
        START = 1'b1;
        tick();
        tick();
        es0 = cyc;
        START = 1'b0;
        check_frame("f4a", b, dn, sc, 1, 1'b0);
        check_frame("f4b", b + NP, dn + 1, es0, 1, 1'b0);
        repeat (3) tick();

        // ready held low for 5 cycles on eop
        rmode = 2;
        es0 = eop_stall;
        b = accq.size(); dn = done_n;
        pulse_start(1'b0, sc);
        check_frame("hold", b, dn, sc, 0, 1'b0);
        chk("eop stall", eop_stall - es0, 5);
        rmode = 0;
        repeat (3) tick();

        // Reset mid-frame, then a full frame with direction re-latched
        b = accq.size(); dn = done_n;
        pulse_start(1'b1, sc);
        wait_acc("rst", b + 4);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort outs", {BUSY, DONE, addr, rden, valid, sop, eop, dataout_re, dataout_im, inverse, error}, 0);
        repeat (3) tick();
        chk("abort no done", done_n - dn, 0);
        RST = 1'b0;
        tick();
        b = accq.size(); dn = done_n;
        pulse_start(1'b1, sc);
        INVERSE = 1'b0;
        check_frame("f6", b, dn, sc, 1, 1'b1);
        repeat (5) tick();

        chk("stall stable", stab_bad, 0);
        chk("credit bound", inv_bad, 0);
        chk("addr max", max_addr, NP - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
